// File: rtl/countdown_timer.sv
//==============================================================================
// Module      : countdown_timer
// Description : Loadable N-bit down-counter with one-shot and auto-reload
//               modes, level-sensitive pause and a one-cycle terminal-count
//               pulse. All outputs are registered.
// Ports       : clk      - clock, all state changes on the rising edge
//               rst      - synchronous active-high reset
//               i_load   - capture i_din into count and the reload register
//               i_din    - load value
//               i_start  - begin counting from the current count (IDLE only)
//               i_pause  - freeze while running
//               i_auto   - 1 = reload at terminal count, 0 = one-shot
//               o_count  - current count value
//               o_tc     - one-cycle terminal-count pulse
//               o_busy   - high while in RUN or HOLD
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module countdown_timer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [N-1:0] i_din,
    input  logic         i_start,
    input  logic         i_pause,
    input  logic         i_auto,
    output logic [N-1:0] o_count,
    output logic         o_tc,
    output logic         o_busy
);

    localparam logic [N-1:0] c_ZERO = '0;
    localparam logic [N-1:0] c_ONE  = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_count;
    logic [N-1:0] r_reload;
    logic         r_tc;
    logic         r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= c_ZERO;
            r_reload <= c_ZERO;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
        end else if (i_load) begin
            // Load aborts any active run without producing a terminal pulse.
            r_state  <= ST_IDLE;
            r_count  <= i_din;
            r_reload <= i_din;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A zero count has nothing to time, so start is ignored.
                    if (i_start && (r_count != c_ZERO)) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_pause) begin
                        // Pause wins even on the terminal edge; tc is deferred.
                        r_state <= ST_HOLD;
                    end else if (r_count > c_ONE) begin
                        r_count <= r_count - c_ONE;
                    end else begin
                        // Terminal edge: load reload or zero, never wrap.
                        r_tc <= 1'b1;
                        if (i_auto) begin
                            r_count <= r_reload;
                        end else begin
                            r_count <= c_ZERO;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    // Release returns to RUN; decrement resumes one edge later.
                    if (!i_pause) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_count = r_count;
    assign o_tc    = r_tc;
    assign o_busy  = r_busy;

endmodule

`default_nettype wire
